// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, flag indices, operand classes
// and constructors for special encodings at arbitrary exponent/fraction widths.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RD  = 3'b010;
  localparam logic [2:0] RM_RU  = 3'b011;
  localparam logic [2:0] RM_RNA = 3'b100;

  localparam int unsigned NFLAGS  = 5;
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_nz, input logic frac_msb);
    fp_class_e c;
    if (exp_zero) begin
      c = frac_nz ? CLS_SUB : CLS_ZERO;
    end else if (exp_ones) begin
      if (!frac_nz) c = CLS_INF;
      else          c = frac_msb ? CLS_QNAN : CLS_SNAN;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  // Encodings are built in 64 bits; callers narrow to their own width (W <= 64).
  function automatic logic [63:0] fp_qnan(input int unsigned ew, input int unsigned mw);
    logic [63:0] r;
    r = (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    return r;
  endfunction

  function automatic logic [63:0] fp_inf(input int unsigned ew, input int unsigned mw,
                                         input logic sign);
    logic [63:0] r;
    r = (((64'd1 << ew) - 64'd1) << mw) | (64'(sign) << (ew + mw));
    return r;
  endfunction

  function automatic logic [63:0] fp_max_finite(input int unsigned ew, input int unsigned mw,
                                                input logic sign);
    logic [63:0] r;
    r = (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1) | (64'(sign) << (ew + mw));
    return r;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage of the multiplier: normalise the raw significand product, round,
// detect overflow/underflow (flush-to-zero) and pack the result.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23,
  localparam int unsigned W  = 1 + EW + MW,
  localparam int unsigned PW = 2 * (MW + 1),
  localparam int unsigned XW = EW + 2
) (
  input  logic                 sign_i,
  input  logic signed [XW-1:0] exp_i,
  input  logic [PW-1:0]        prod_i,
  input  logic [2:0]           rm_i,
  output logic [W-1:0]         res_c_o,
  output logic [NFLAGS-1:0]    flags_c_o
);

  localparam int unsigned MANW = MW + 1;

  logic [PW-1:0]        norm;
  logic [MANW-1:0]      mant;
  logic [MANW:0]        mant_r;
  logic                 g, t, up, carry, uf, of;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [MW-1:0]        frac;

  // A product in [2,4) is shifted down one place; in [1,2) it is already normal.
  always_comb begin
    norm  = prod_i[PW-1] ? prod_i : (prod_i << 1);
    mant  = norm[PW-1 -: MANW];
    g     = norm[PW-1-MANW];
    t     = |norm[PW-2-MANW:0];
    exp_n = exp_i + $signed(XW'(prod_i[PW-1]));
  end

  always_comb begin
    up = 1'b0;
    case (rm_i)
      RM_RZ:   up = 1'b0;
      RM_RD:   up = sign_i & (g | t);
      RM_RU:   up = ~sign_i & (g | t);
      RM_RNA:  up = g;
      default: up = g & (t | mant[0]);
    endcase
  end

  always_comb begin
    mant_r = {1'b0, mant} + (MANW + 1)'(up);
    carry  = mant_r[MANW];
    exp_r  = exp_n + $signed(XW'(carry));
    frac   = carry ? '0 : mant_r[MW-1:0];
    uf     = exp_n < $signed(XW'(1));
    of     = exp_r >= $signed(XW'((1 << EW) - 1));
  end

  always_comb begin
    res_c_o            = {sign_i, exp_r[EW-1:0], frac};
    flags_c_o          = '0;
    flags_c_o[FLAG_DZ] = 1'b0;
    flags_c_o[FLAG_NX] = g | t;
    if (uf) begin
      res_c_o            = {sign_i, (W - 1)'(0)};
      flags_c_o[FLAG_UF] = 1'b1;
      flags_c_o[FLAG_NX] = 1'b1;
    end else if (of) begin
      flags_c_o[FLAG_OF] = 1'b1;
      flags_c_o[FLAG_NX] = 1'b1;
      case (rm_i)
        RM_RZ:   res_c_o = W'(fp_max_finite(EW, MW, sign_i));
        RM_RD:   res_c_o = sign_i ? W'(fp_inf(EW, MW, 1'b1)) : W'(fp_max_finite(EW, MW, 1'b0));
        RM_RU:   res_c_o = sign_i ? W'(fp_max_finite(EW, MW, 1'b1)) : W'(fp_inf(EW, MW, 1'b0));
        default: res_c_o = W'(fp_inf(EW, MW, sign_i));
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (decode/special, multiply, round/pack) with a
// single shared advance so the whole pipe holds under output backpressure.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EW   = 8,
  parameter int unsigned MW   = 23,
  parameter int unsigned TAGW = 4,
  localparam int unsigned W   = 1 + EW + MW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic [2:0]        in_rm,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_res,
  output logic [TAGW-1:0]   out_tag,
  output logic [NFLAGS-1:0] out_flags
);

  localparam int unsigned MANW = MW + 1;
  localparam int unsigned PW   = 2 * MANW;
  localparam int unsigned XW   = EW + 2;
  localparam int unsigned BIAS = (1 << (EW - 1)) - 1;

  logic adv;

  logic sa, sb, sign_d;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  fp_class_e ca, cb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_snan;
  logic spec_d, nv_d;
  logic [W-1:0] spec_res_d;
  logic [2:0] rm_d;

  logic              s1_vld_q, s1_sign_q, s1_spec_q, s1_nv_q;
  logic [TAGW-1:0]   s1_tag_q;
  logic [2:0]        s1_rm_q;
  logic [W-1:0]      s1_spec_res_q;
  logic [EW-1:0]     s1_ea_q, s1_eb_q;
  logic [MANW-1:0]   s1_ma_q, s1_mb_q;

  logic [PW-1:0]        prod_d;
  logic signed [XW-1:0] exp_d;

  logic                 s2_vld_q, s2_sign_q, s2_spec_q, s2_nv_q;
  logic [TAGW-1:0]      s2_tag_q;
  logic [2:0]           s2_rm_q;
  logic [W-1:0]         s2_spec_res_q;
  logic [PW-1:0]        s2_prod_q;
  logic signed [XW-1:0] s2_exp_q;

  logic [W-1:0]      rp_res, res_d;
  logic [NFLAGS-1:0] rp_flags, flags_d;

  logic              out_valid_q;
  logic [W-1:0]      out_res_q;
  logic [TAGW-1:0]   out_tag_q;
  logic [NFLAGS-1:0] out_flags_q;

  assign adv       = out_ready | ~out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign out_flags = out_flags_q;

  // Stage 1: classify operands (subnormals read as zero) and resolve specials.
  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign sign_d = sa ^ sb;
  assign ca = fp_classify(ea == '0, &ea, |fa, fa[MW-1]);
  assign cb = fp_classify(eb == '0, &eb, |fb, fb[MW-1]);
  assign rm_d = (in_rm > RM_RNA) ? RM_RNE : in_rm;

  always_comb begin
    a_nan      = (ca == CLS_QNAN) || (ca == CLS_SNAN);
    b_nan      = (cb == CLS_QNAN) || (cb == CLS_SNAN);
    a_inf      = ca == CLS_INF;
    b_inf      = cb == CLS_INF;
    a_zero     = (ca == CLS_ZERO) || (ca == CLS_SUB);
    b_zero     = (cb == CLS_ZERO) || (cb == CLS_SUB);
    any_snan   = (ca == CLS_SNAN) || (cb == CLS_SNAN);
    spec_d     = 1'b1;
    nv_d       = 1'b0;
    spec_res_d = '0;
    if (a_nan || b_nan) begin
      spec_res_d = W'(fp_qnan(EW, MW));
      nv_d       = any_snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res_d = W'(fp_qnan(EW, MW));
      nv_d       = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res_d = W'(fp_inf(EW, MW, sign_d));
    end else if (a_zero || b_zero) begin
      spec_res_d = {sign_d, (W - 1)'(0)};
    end else begin
      spec_d = 1'b0;
    end
  end

  // Stage 2: full-width significand product and signed biased exponent sum.
  assign prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
  assign exp_d  = $signed(XW'(s1_ea_q) + XW'(s1_eb_q) - XW'(BIAS));

  // Stage 3: round/pack, with special results bypassing the arithmetic.
  fp_round_pack #(
    .EW (EW),
    .MW (MW)
  ) u_round_pack (
    .sign_i    (s2_sign_q),
    .exp_i     (s2_exp_q),
    .prod_i    (s2_prod_q),
    .rm_i      (s2_rm_q),
    .res_c_o   (rp_res),
    .flags_c_o (rp_flags)
  );

  always_comb begin
    res_d   = rp_res;
    flags_d = rp_flags;
    if (s2_spec_q) begin
      res_d            = s2_spec_res_q;
      flags_d          = '0;
      flags_d[FLAG_NV] = s2_nv_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_nv_q       <= 1'b0;
      s1_tag_q      <= '0;
      s1_rm_q       <= '0;
      s1_spec_res_q <= '0;
      s1_ea_q       <= '0;
      s1_eb_q       <= '0;
      s1_ma_q       <= '0;
      s1_mb_q       <= '0;
      s2_vld_q      <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_nv_q       <= 1'b0;
      s2_tag_q      <= '0;
      s2_rm_q       <= '0;
      s2_spec_res_q <= '0;
      s2_prod_q     <= '0;
      s2_exp_q      <= '0;
      out_valid_q   <= 1'b0;
      out_res_q     <= '0;
      out_tag_q     <= '0;
      out_flags_q   <= '0;
    end else if (adv) begin
      s1_vld_q      <= in_valid;
      s1_sign_q     <= sign_d;
      s1_spec_q     <= spec_d;
      s1_nv_q       <= nv_d;
      s1_tag_q      <= in_tag;
      s1_rm_q       <= rm_d;
      s1_spec_res_q <= spec_res_d;
      s1_ea_q       <= ea;
      s1_eb_q       <= eb;
      s1_ma_q       <= {1'b1, fa};
      s1_mb_q       <= {1'b1, fb};
      s2_vld_q      <= s1_vld_q;
      s2_sign_q     <= s1_sign_q;
      s2_spec_q     <= s1_spec_q;
      s2_nv_q       <= s1_nv_q;
      s2_tag_q      <= s1_tag_q;
      s2_rm_q       <= s1_rm_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_prod_q     <= prod_d;
      s2_exp_q      <= exp_d;
      out_valid_q   <= s2_vld_q;
      out_res_q     <= res_d;
      out_tag_q     <= s2_tag_q;
      out_flags_q   <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (binary32 configuration) against an
// integer-arithmetic reference model of IEEE multiplication with DAZ/FTZ.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_rm;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic [4:0]  out_flags;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];

  fp_mul_pipe #(.EW(8), .MW(23), .TAGW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Exact product, then round by comparing the discarded remainder with one half-ulp.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm_in,
                                  output logic [31:0] res, output logic [4:0] fl);
    logic s, up;
    int ea, eb, e, sh;
    longint unsigned fa, fb, p, q, rem, half;
    logic [2:0] rm;
    bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = 64'(a[22:0]);
    fb = 64'(b[22:0]);
    fl = 5'b0;
    a_nan  = (ea == 255) && (fa != 0);
    b_nan  = (eb == 255) && (fb != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (ea == 255) && (fa == 0);
    b_inf  = (eb == 255) && (fb == 0);
    a_zero = ea == 0;
    b_zero = eb == 0;
    if (a_nan || b_nan) begin
      res = 32'h7FC0_0000; fl[4] = a_snan || b_snan; return;
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 32'h7FC0_0000; fl = 5'b10000; return;
    end
    if (a_inf || b_inf) begin
      res = {s, 8'hFF, 23'h0}; return;
    end
    if (a_zero || b_zero) begin
      res = {s, 31'h0}; return;
    end
    p = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (e < 1) begin
      res = {s, 31'h0}; fl = 5'b00011; return;
    end
    case (rm)
      3'd0:    up = (rem > half) || ((rem == half) && q[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      default: up = rem >= half;
    endcase
    if (up) q = q + 1;
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
    if (e >= 255) begin
      fl = 5'b00101;
      case (rm)
        3'd1:    res = {s, 31'h7F7F_FFFF};
        3'd2:    res = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        3'd3:    res = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: res = {s, 31'h7F80_0000};
      endcase
      return;
    end
    res   = {s, 8'(e), 23'(q)};
    fl[0] = rem != 0;
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 99);
    r = $urandom;
    if (k < 55)      r[30:23] = 8'($urandom_range(110, 145));
    else if (k < 67) r[30:23] = 8'($urandom_range(180, 254));
    else if (k < 77) r[30:23] = 8'($urandom_range(1, 70));
    else if (k < 81) r[30:0]  = 31'h0;
    else if (k < 85) r[30:23] = 8'h00;
    else if (k < 89) begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
    else if (k < 94) r[30:23] = 8'hFF;
    return r;
  endfunction

  // One clock: drive inputs at the falling edge, observe settled outputs, push accepts.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                      input logic [3:0] tag, input logic ordy,
                      output logic acc, output logic rdy, output logic ovld, output logic got,
                      output logic [31:0] res, output logic [4:0] fl, output logic [3:0] otag);
    logic [31:0] er;
    logic [4:0]  ef;
    in_valid = v; in_a = a; in_b = b; in_rm = rm; in_tag = tag; out_ready = ordy;
    #1;
    rdy  = in_ready;
    acc  = v & in_ready;
    ovld = out_valid;
    got  = out_valid & ordy;
    res  = out_res;
    fl   = out_flags;
    otag = out_tag;
    if (acc) begin
      ref_mul(a, b, rm, er, ef);
      sb_q.push_back('{res: er, flags: ef, tag: tag});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_rm = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({out_valid, out_res, out_tag, out_flags} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b res=%h tag=%h flags=%b, want all zero",
               out_valid, out_res, out_tag, out_flags);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] da[13] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                            32'h7F000000, 32'hFF000000, 32'hFF000000, 32'h7F800000, 32'h7F800001,
                            32'h80000000, 32'h00800000, 32'h3F800001};
    logic [31:0] db[13] = '{32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h40000000,
                            32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000, 32'h3F800000,
                            32'h3F800000, 32'h3F000000, 32'h3FC00000};
    logic [2:0]  dm[13] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
    logic [31:0] dr[13] = '{32'h40400000, 32'h3FC00002, 32'h3FC00001, 32'h3FC00002, 32'h7F800000,
                            32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                            32'h80000000, 32'h00000000, 32'h3FC00002};
    logic [4:0]  df[13] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00101, 5'b00101,
                            5'b00101, 5'b10000, 5'b10000, 5'b00000, 5'b00011, 5'b00001};
    logic acc, rdy, ovld, got;
    logic [31:0] res;
    logic [4:0] fl;
    logic [3:0] otag;
    int lat;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, da[i], db[i], dm[i], 4'(i), 1'b1, acc, rdy, ovld, got, res, fl, otag);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
        step(1'b0, 32'h0, 32'h0, 3'd0, 4'h0, 1'b1, acc, rdy, ovld, got, res, fl, otag);
        lat++;
      end
      n_tests++;
      if (!got || lat != 3 || res !== dr[i] || fl !== df[i] || otag !== 4'(i)) begin
        n_fail++;
        $display("FAIL directed_%0d: got res=%h flags=%b tag=%h latency=%0d seen=%b, want res=%h flags=%b tag=%h latency=3",
                 i, res, fl, otag, lat, got, dr[i], df[i], 4'(i));
      end
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic acc, rdy, ovld, got, seen_valid;
    logic [31:0] res;
    logic [4:0] fl;
    logic [3:0] otag;
    int idx, nres, first_cyc;
    exp_t e;
    idx = 0; nres = 0; first_cyc = -1; seen_valid = 1'b0;
    for (int c = 0; c < 40 && nres < 6; c++) begin
      step(idx < 6, rand_op(), rand_op(), 3'($urandom_range(0, 4)), 4'(idx), c >= 4,
           acc, rdy, ovld, got, res, fl, otag);
      if (ovld && !seen_valid) begin
        seen_valid = 1'b1;
        first_cyc  = c;
        n_tests++;
        if (rdy !== 1'b0 || c != 3) begin
          n_fail++;
          $display("FAIL bp_ready_drop: got in_ready=%b at cycle %0d, want 0 at cycle 3", rdy, c);
        end
      end
      if (acc) idx++;
      if (got) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_spurious: got tag=%h with nothing outstanding", otag);
        end else begin
          e = sb_q.pop_front();
          if ({res, fl, otag} !== e || otag !== 4'(nres)) begin
            n_fail++;
            $display("FAIL bp_result_%0d: got res=%h flags=%b tag=%h, want res=%h flags=%b tag=%h",
                     nres, res, fl, otag, e.res, e.flags, 4'(nres));
          end
        end
        nres++;
      end
    end
    n_tests++;
    if (nres != 6 || idx != 6 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results from %0d accepts (%0d left), want 6/6/0 (first valid cycle %0d)",
               nres, idx, sb_q.size(), first_cyc);
    end
    sb_q.delete();
  endtask

  task automatic test_random();
    logic acc, rdy, ovld, got, ordy, prev_stall;
    logic [31:0] res, prev_res;
    logic [4:0] fl, prev_fl;
    logic [3:0] otag, prev_tag;
    exp_t e;
    int tag;
    tag = 0; prev_stall = 1'b0; prev_res = '0; prev_fl = '0; prev_tag = '0;
    for (int c = 0; c < 460; c++) begin
      ordy = (c >= 420) || ($urandom_range(0, 9) < 7);
      step((c < 420) && ($urandom_range(0, 9) < 7), rand_op(), rand_op(), 3'($urandom_range(0, 7)),
           4'(tag), ordy, acc, rdy, ovld, got, res, fl, otag);
      if (acc) tag++;
      if (prev_stall) begin
        n_tests++;
        if (!ovld || {res, fl, otag} !== {prev_res, prev_fl, prev_tag}) begin
          n_fail++;
          $display("FAIL rand_stall_hold: got valid=%b res=%h flags=%b tag=%h, want held res=%h flags=%b tag=%h",
                   ovld, res, fl, otag, prev_res, prev_fl, prev_tag);
        end
      end
      prev_stall = ovld && !ordy;
      prev_res = res; prev_fl = fl; prev_tag = otag;
      if (got) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: got res=%h tag=%h with nothing outstanding", res, otag);
        end else begin
          e = sb_q.pop_front();
          if ({res, fl, otag} !== e) begin
            n_fail++;
            $display("FAIL rand_result: got res=%h flags=%b tag=%h, want res=%h flags=%b tag=%h",
                     res, fl, otag, e.res, e.flags, e.tag);
          end
        end
      end
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d results still outstanding, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    logic acc, rdy, ovld, got;
    logic [31:0] res;
    logic [4:0] fl;
    logic [3:0] otag;
    int stale, waited;
    for (int i = 0; i < 3; i++)
      step(1'b1, rand_op(), rand_op(), 3'd0, 4'(i), 1'b0, acc, rdy, ovld, got, res, fl, otag);
    waited = 0;
    ovld = out_valid;
    while (!ovld && waited < 6) begin
      step(1'b0, 32'h0, 32'h0, 3'd0, 4'h0, 1'b0, acc, rdy, ovld, got, res, fl, otag);
      waited++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_fill: got out_valid=%b before reset, want 1", out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got out_valid=%b during reset, want 0", out_valid);
    end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 32'h0, 3'd0, 4'h0, 1'b1, acc, rdy, ovld, got, res, fl, otag);
      if (ovld) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: got %0d cycles of out_valid after reset, want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised IEEE-754 binary floating-point multiplier, 3-stage pipeline, valid/ready handshake on both sides.
- Successor to the single-precision multiplier:
  - exponent and mantissa widths are generic;
  - a sideband tag is carried through the pipe;
  - backpressure is supported;
  - all five rounding modes are handled, including overflow saturation.
- Sits between the FPU issue logic and the writeback arbiter.

Parameters:
- EW, 8, exponent field width.
- MW, 23, stored fraction width (hidden bit excluded).
- TAGW, 4, sideband tag width, passed through unchanged.
- Derived, not overridable: W = 1+EW+MW; BIAS = 2^(EW-1)-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_rm  in  3  rounding mode.
- in_tag  in  TAGW  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  W  product.
- out_tag  out  TAGW  tag accompanying the result.
- out_flags  out  5  {invalid, divzero(always 0), overflow, underflow, inexact}.

Behaviour:
- Reset: every stage valid bit cleared. out_valid=0, out_res=0, out_tag=0, out_flags=0. in_ready=1 once rst deasserts. Reset mid-operation discards all in-flight results.
- Advance: adv = out_ready | ~out_valid. in_ready = adv.
  - A transfer occurs on in_valid & in_ready.
  - All stages shift together on adv; otherwise all stages hold.
  - Bubbles are not collapsed.
- Latency: 3 cycles from accept to out_valid when out_ready is held high. Throughput is 1 per cycle.
- out_* is stable while out_valid & ~out_ready.
- Stage 1 (decode/special):
  - sign = sa^sb.
  - Classify each operand: zero, subnormal, normal, inf, qNaN, sNaN.
  - DAZ: subnormal inputs are treated as signed zero, no flag.
  - Specials, in priority order:
    - any NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1); invalid=1 if either operand is sNaN.
    - inf×0 -> qNaN, invalid=1.
    - inf×finite or inf×inf -> signed inf.
    - zero×finite -> signed zero.
  - Special results bypass the arithmetic and are forwarded with the tag.
- Stage 2 (multiply):
  - (1.fa)×(1.fb) is unsigned, 2(MW+1) bits.
  - Exponent sum ea+eb-BIAS is held signed in EW+2 bits; no wrap is allowed.
- Stage 3 (normalise/round/pack):
  - If the product MSB is set, shift right 1 and exponent+1.
  - g = bit below the LSB; t = OR of all lower bits.
  - Round-up decision:
    - RNE: g&(t|lsb).
    - RNA: g.
    - RZ: never.
    - RD: sign&(g|t).
    - RU: ~sign&(g|t).
  - Rounding carry-out of the mantissa -> fraction 0, exponent+1.
- Overflow: final biased exponent >= 2^EW-1. Sets overflow=1 and inexact=1. Result by mode:
  - RNE/RNA: signed inf.
  - RZ: signed max finite.
  - RD: +max finite if positive, -inf if negative.
  - RU: +inf if positive, -max finite if negative.
- Underflow: normalised pre-round biased exponent < 1. FTZ: result is signed zero, underflow=1, inexact=1.
- inexact = g|t for normal results.
- in_rm encodings 101–111 are treated as RNE.

Decomposition:
- Package fp_pkg holds:
  - rounding-mode constants: RNE=000, RZ=001, RD=010, RU=011, RNA=100;
  - flag bit indices;
  - the operand class enum;
  - functions for qNaN/inf/max-finite construction, parametrised by EW/MW.
- One sub-module: fp_round_pack (stage-3 combinational normalise/round/overflow logic). The top level holds the pipeline registers and handshake.

Test Plan:
1. RNE, 0x3FC00000×0x40000000, out_ready=1 -> 0x40400000 on the third cycle after accept, flags=0, tag echoed.
2. 0x3F800001×0x3FC00000 (tie case):
   - RNE -> 0x3FC00002, inexact=1.
   - RZ -> 0x3FC00001, inexact=1.
   - RNA -> 0x3FC00002.
3. 0x7F000000×0x40000000:
   - RNE -> 0x7F800000, overflow=1, inexact=1.
   - RZ -> 0x7F7FFFFF.
   - RU on the negated product (0xFF000000×0x40000000) -> 0xFF7FFFFF.
4. Specials:
   - 0x7F800000×0x00000000 -> 0x7FC00000, invalid=1.
   - 0x7F800001×0x3F800000 -> 0x7FC00000, invalid=1.
   - 0x80000000×0x3F800000 -> 0x80000000, flags=0.
5. 0x00800000×0x3F000000 -> 0x00000000, underflow=1, inexact=1.
6. Backpressure and reset:
   - 6 back-to-back inputs (tags 0–5) with out_ready low for 4 cycles -> in_ready drops in the cycle out_valid rises; all 6 results emerge in tag order, none lost or duplicated.
   - rst asserted mid-stream -> out_valid=0 immediately, no stale results after release.
